// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle shared by the two writers, the arbiter and the register file.
// The arbiter drives the grant and register-file side through the slave modport.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              ReqA;
  logic [ADDR_W-1:0] AddrA;
  logic [DATA_W-1:0] DataA;
  logic              GntA;
  logic              ReqB;
  logic [ADDR_W-1:0] AddrB;
  logic [DATA_W-1:0] DataB;
  logic              GntB;
  logic              RfWrite;
  logic [ADDR_W-1:0] RfWriteAddr;
  logic [DATA_W-1:0] RfDataIn;
  logic              AddrErr;
  logic              Busy;

  modport master (
    output ReqA, AddrA, DataA, ReqB, AddrB, DataB,
    input  GntA, GntB, RfWrite, RfWriteAddr, RfDataIn, AddrErr, Busy
  );

  modport slave (
    input  ReqA, AddrA, DataA, ReqB, AddrB, DataB,
    output GntA, GntB, RfWrite, RfWriteAddr, RfDataIn, AddrErr, Busy
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin owner of the regFile16b8 write port; all register-file controls are registered.
// Optional zero-fill of every register after reset or on ClearReq when RF_CLEAR_EN is defined.
module rf_write_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 8
) (
  input  logic CLK,
  input  logic Reset_n,
`ifdef RF_CLEAR_EN
  input  logic ClearReq,
`endif
  rf_write_arbiter_if.slave bus
);

  logic              lastB;
  logic              allowGrant;
  logic              gntA;
  logic              gntB;
  logic              clearing;
  logic              addrValid;
  logic [ADDR_W-1:0] selAddr;
  logic [ADDR_W-1:0] clearAddr;
  logic [DATA_W-1:0] selData;

`ifdef RF_CLEAR_EN
  typedef enum logic {RUN, CLEAR} state_t;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cntNext;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // NOTE: defaults come first so every path assigns every output; a missed path would infer a latch.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      RUN: begin
        if (ClearReq) begin
          stateNext = CLEAR;
          cntNext   = '0;
        end
      end
      CLEAR: begin
        cntNext = cnt + 1'b1;
        if (cnt == ADDR_W'(NUM_REGS - 1)) stateNext = RUN;
      end
    endcase
  end

  assign clearing   = (state == CLEAR);
  // The edge that accepts ClearReq must not also complete a transfer.
  assign allowGrant = Reset_n && (state == RUN) && !ClearReq;
  assign clearAddr  = cnt;
`else
  assign clearing   = 1'b0;
  assign allowGrant = Reset_n;
  assign clearAddr  = '0;
`endif

  // On a tie, the writer that did not win last time gets the port.
  assign gntA = allowGrant && bus.ReqA && (!bus.ReqB || lastB);
  assign gntB = allowGrant && bus.ReqB && (!bus.ReqA || !lastB);

  assign bus.GntA = gntA;
  assign bus.GntB = gntB;
  assign bus.Busy = clearing;

  assign selAddr   = gntA ? bus.AddrA : bus.AddrB;
  assign selData   = gntA ? bus.DataA : bus.DataB;
  assign addrValid = int'(selAddr) < NUM_REGS;

  // NOTE: non-blocking assignments so every flop here samples the pre-edge values of its peers.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      lastB           <= 1'b1;
      bus.RfWrite     <= 1'b0;
      bus.RfWriteAddr <= '0;
      bus.RfDataIn    <= '0;
      bus.AddrErr     <= 1'b0;
    end else if (clearing) begin
      bus.RfWrite     <= 1'b1;
      bus.RfWriteAddr <= clearAddr;
      bus.RfDataIn    <= '0;
      bus.AddrErr     <= 1'b0;
    end else if (gntA || gntB) begin
      // An out-of-range target still completes the handshake but never reaches the file.
      bus.RfWrite     <= addrValid;
      bus.RfWriteAddr <= selAddr;
      bus.RfDataIn    <= selData;
      bus.AddrErr     <= !addrValid;
      lastB           <= gntB;
    end else begin
      bus.RfWrite     <= 1'b0;
      bus.AddrErr     <= 1'b0;
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port of the 16-bit register file (regFile16b8).
- Arbitrates round-robin between two writers: A = ALU/accumulator writeback, B = memory-load return.
- Drives the register file's Write/WriteAddr/DataIn from registered outputs, so the register file sees clean, glitch-free controls.
- Optionally runs a zero-fill sequence across all registers after reset or on command.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width
- NUM_REGS, 8, number of implemented registers; addresses >= NUM_REGS are invalid

Ports:
- CLK  in  1  system clock, rising-edge
- Reset_n  in  1  asynchronous active-low reset
- ReqA  in  1  writer A request; held until granted
- AddrA  in  ADDR_W  writer A target register
- DataA  in  DATA_W  writer A data
- GntA  out  1  writer A granted this cycle (combinational)
- ReqB, AddrB, DataB, GntB  same as A, for writer B
- RfWrite  out  1  to register file Write
- RfWriteAddr  out  ADDR_W  to register file WriteAddr
- RfDataIn  out  DATA_W  to register file DataIn
- AddrErr  out  1  one-cycle pulse: granted write had an invalid address
- Busy  out  1  high while the clear sequence runs (always 0 without RF_CLEAR_EN)

Behaviour:
- Reset (Reset_n=0, async):
  - RfWrite=0, RfWriteAddr=0, RfDataIn=0, AddrErr=0, GntA=GntB=0.
  - Round-robin pointer Last=B, so A wins the first tie.
- State RUN, grant rules:
  - Only ReqA high: GntA=1. Only ReqB high: GntB=1.
  - Both high: grant the writer not equal to Last.
  - GntA and GntB are never high together.
- Handshake:
  - A transfer occurs on a rising edge where Req=1 and Gnt=1.
  - The requester may change Addr/Data or drop Req only after a transfer edge.
  - Req, Addr and Data must stay stable while ungranted.
- Write latency:
  - At the transfer edge: RfWrite<=1, RfWriteAddr<=Addr, RfDataIn<=Data, Last<=granted writer.
  - The register file commits on the following edge, so data is readable 2 edges after transfer.
- Idle: if no transfer on an edge, RfWrite<=0 and RfWriteAddr/RfDataIn hold their values.
- Back-to-back: with both writers requesting continuously, grants alternate A,B,A,B and RfWrite stays 1 every cycle.
- Invalid address (Addr >= NUM_REGS):
  - Transfer still completes; the requester is not stalled.
  - RfWrite<=0 and AddrErr<=1 for one cycle.
- RfWriteAddr width: ADDR_W, zero-extended, no wrap.
- Reset mid-operation: the in-flight write is dropped (RfWrite forced 0); the requester must re-request.

Optional Feature:
- Macro RF_CLEAR_EN.
- Defined:
  - Adds state CLEAR, a counter Cnt[ADDR_W-1:0] and an input ClearReq (in, 1).
  - Reset enters CLEAR with Cnt=0 and Busy=1.
  - In CLEAR, each edge: RfWrite<=1, RfWriteAddr<=Cnt, RfDataIn<=0, Cnt<=Cnt+1. GntA=GntB=0.
  - The edge issuing address NUM_REGS-1 moves to RUN and clears Busy. Total: NUM_REGS edges.
  - ClearReq=1 in RUN re-enters CLEAR at the next edge with Cnt=0. That edge performs no grant, so any concurrent request stalls.
  - ClearReq while already in CLEAR is ignored; the sequence does not restart.
- Undefined: no ClearReq port, reset goes straight to RUN, Busy tied 0.

Test Plan:
- ReqA=1, AddrA=3, DataA=16'h00AA -> GntA=1 same cycle; next cycle RfWrite=1, RfWriteAddr=3, RfDataIn=00AA; ReadDataA at address 3 = 00AA after one more edge.
- ReqA=ReqB=1 held 4 cycles, AddrA=1/DataA=1, AddrB=2/DataB=2 -> grant order A,B,A,B; RfWrite high 4 consecutive cycles; GntA&GntB never 1.
- ReqB=1, AddrB=9 (NUM_REGS=8) -> GntB=1; next cycle RfWrite=0, AddrErr=1 for exactly one cycle.
- Write 16'h1234 to register 5, then pulse Reset_n low mid-write -> RfWrite=0 immediately and all outputs at reset values.
- With RF_CLEAR_EN: release reset -> 8 cycles of RfWrite=1, addresses 0..7, data 0; Busy falls after 8 edges; ReqA asserted during Busy is granted only after Busy=0.
- With RF_CLEAR_EN: pulse ClearReq in RUN with ReqA pending -> no GntA that cycle, Busy=1, clear reruns 0..7, then GntA=1.
